// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//   APB requester bridging the CPU data-bus request interface onto an APB bus
//   with NUM_SLAVES peripherals. One request is in flight at a time. The slave
//   is selected by i_addr[15:12], and the access is only legal when
//   i_addr[31:16] == BASE_HI. Undecodable requests complete with an error and
//   never drive PSEL. An access that sees no PREADY for TIMEOUT_CYCLES ACCESS
//   cycles is aborted with an error.
//
// Handshake:
//   i_transfer is the request valid. It is sampled only while the bridge is
//   idle (o_busy == 0). Requests presented while o_busy == 1 are dropped, not
//   queued. Every accepted request ends with exactly one o_ready pulse, which
//   lasts one cycle. o_error qualifies that pulse. o_rdata is valid from the
//   pulse of a successful read and holds until the next successful read.
//
// Ports:
//   PCLK, PRESET         clock (rising edge), async active-low reset
//   i_transfer, i_write  request strobe and direction (1 = write)
//   i_addr, i_wdata      byte address and write data
//   o_rdata              last successful read data (registered)
//   o_ready, o_error     completion pulse and its error qualifier
//   o_busy               high whenever a request is being processed
//   PADDR, PWDATA,
//   PWRITE, PSEL,
//   PENABLE              APB requester outputs, all registered
//   PRDATA_ALL           slave read data, slave k at [32k+31:32k]
//   PREADY_ALL           slave ready, bit k for slave k
//   dbg_state            current FSM state (IDLE=0, SETUP=1, ACCESS=2, DONE=3)
// -----------------------------------------------------------------------------
module apb_master #(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [15:0] BASE_HI        = 16'h1000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      i_transfer,
  input  logic                      i_write,
  input  logic [31:0]               i_addr,
  input  logic [31:0]               i_wdata,
  output logic [31:0]               o_rdata,
  output logic                      o_ready,
  output logic                      o_error,
  output logic                      o_busy,
  output logic [11:0]               PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic [NUM_SLAVES-1:0]     PSEL,
  output logic                      PENABLE,
  input  logic [32*NUM_SLAVES-1:0]  PRDATA_ALL,
  input  logic [NUM_SLAVES-1:0]     PREADY_ALL,
  output logic [1:0]                dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               addr_ok;
  logic [NUM_SLAVES-1:0] req_sel;
  logic [31:0]        sel_rdata;
  logic               sel_ready;

  // Address decode of the incoming request.
  assign addr_ok = (i_addr[31:16] == BASE_HI) &&
                   ({28'd0, i_addr[15:12]} < 32'(NUM_SLAVES));
  assign req_sel = NUM_SLAVES'(1) << i_addr[15:12];

  // PSEL holds the latched one-hot selection for the whole transfer, so it
  // doubles as the mux select for the returning slave signals. PREADY and
  // PRDATA of unselected slaves never reach the FSM.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (PSEL[k]) begin
        sel_rdata = PRDATA_ALL[32*k +: 32];
        sel_ready = PREADY_ALL[k];
      end
    end
  end

  assign dbg_state = state;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state    <= IDLE;
      wait_cnt <= '0;
      PSEL     <= '0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      o_rdata  <= '0;
      o_ready  <= 1'b0;
      o_error  <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_ready <= 1'b0;
          o_error <= 1'b0;
          if (i_transfer) begin
            PADDR  <= i_addr[11:0];
            PWDATA <= i_wdata;
            PWRITE <= i_write;
            o_busy <= 1'b1;
            if (addr_ok) begin
              PSEL  <= req_sel;
              state <= SETUP;
            end else begin
              // Undecodable: skip the bus entirely and report in DONE.
              o_ready <= 1'b1;
              o_error <= 1'b1;
              state   <= DONE;
            end
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (sel_ready) begin
            if (!PWRITE) begin
              o_rdata <= sel_rdata;
            end
            PSEL     <= '0;
            PENABLE  <= 1'b0;
            o_ready  <= 1'b1;
            wait_cnt <= '0;
            state    <= DONE;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // This is the TIMEOUT_CYCLES-th ACCESS cycle without PREADY.
            PSEL     <= '0;
            PENABLE  <= 1'b0;
            o_ready  <= 1'b1;
            o_error  <= 1'b1;
            wait_cnt <= '0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        DONE: begin
          o_ready  <= 1'b0;
          o_error  <= 1'b0;
          o_busy   <= 1'b0;
          wait_cnt <= '0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

  localparam int NS      = 4;
  localparam int TIMEOUT = 16;

  logic            PCLK;
  logic            PRESET;
  logic            i_transfer;
  logic            i_write;
  logic [31:0]     i_addr;
  logic [31:0]     i_wdata;
  logic [31:0]     o_rdata;
  logic            o_ready;
  logic            o_error;
  logic            o_busy;
  logic [11:0]     PADDR;
  logic [31:0]     PWDATA;
  logic            PWRITE;
  logic [NS-1:0]   PSEL;
  logic            PENABLE;
  logic [32*NS-1:0] PRDATA_ALL;
  logic [NS-1:0]   PREADY_ALL;
  logic [1:0]      dbg_state;

  apb_master #(
    .NUM_SLAVES     (NS),
    .BASE_HI        (16'h1000),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .i_transfer (i_transfer),
    .i_write    (i_write),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .o_ready    (o_ready),
    .o_error    (o_error),
    .o_busy     (o_busy),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PWRITE     (PWRITE),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PRDATA_ALL (PRDATA_ALL),
    .PREADY_ALL (PREADY_ALL),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- slave models ----------------
  // Slave k inserts wait_n[k] wait cycles (PREADY low) before PREADY; a
  // value >= TIMEOUT means it never responds. Slave 0 is a RAM, the others
  // return a fixed word. Unselected slaves drive random noise.
  int          wait_n[16];
  logic [31:0] fixed_data[16];
  logic [31:0] ram[1024];
  int          acc_cnt;
  logic [NS-1:0] noise;
  logic [31:0]   noise_data;

  always @(negedge PCLK) begin
    noise      <= NS'($urandom);
    noise_data <= $urandom;
  end

  always @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      acc_cnt <= 0;
      for (int i = 0; i < 1024; i++) ram[i] <= '0;
    end else begin
      if ((|PSEL) && PENABLE && !(|(PREADY_ALL & PSEL))) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (PSEL[0] && PENABLE && PREADY_ALL[0] && PWRITE) ram[PADDR[11:2]] <= PWDATA;
    end
  end

  always_comb begin
    PRDATA_ALL = '0;
    PREADY_ALL = '0;
    for (int k = 0; k < NS; k++) begin
      if (PSEL[k]) begin
        PRDATA_ALL[32*k +: 32] = (k == 0) ? ram[PADDR[11:2]] : fixed_data[k];
        PREADY_ALL[k]          = PENABLE && (acc_cnt >= wait_n[k]);
      end else begin
        PRDATA_ALL[32*k +: 32] = noise_data ^ 32'(k);
        PREADY_ALL[k]          = noise[k];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          vectors;
  int          errors;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rdata;
  logic [31:0] model_mem[1024];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_rdata = '0;
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;
  endtask

  // ---------------- driver ----------------
  // Issues one request and follows it to completion. The expected outcome is
  // derived from the address map, slave wait settings and the memory model.
  // With keep_high the strobe stays asserted and the request inputs are
  // scrambled every cycle while the transfer runs; none of that may leak in.
  task automatic do_req(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic keep_high);
    int          k;
    logic        ok;
    logic        exp_err;
    int          exp_acc;
    logic [NS-1:0] exp_psel;
    int          lat;
    int          setup_n;
    int          acc_n;
    logic        done;
    logic [31:0] exp_d;

    k        = int'(addr[15:12]);
    ok       = (addr[31:16] == 16'h1000) && (k < NS);
    exp_err  = !ok || (wait_n[k] >= TIMEOUT);
    exp_acc  = !ok ? 0 : (exp_err ? TIMEOUT : wait_n[k] + 1);
    exp_psel = ok ? NS'(1 << k) : '0;
    if (!exp_err && !wr) exp_rdata = (k == 0) ? model_mem[addr[11:2]] : fixed_data[k];
    if (!exp_err && wr && (k == 0)) model_mem[addr[11:2]] = wdata;
    exp_q.push_back(exp_rdata);

    @(negedge PCLK);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("ready_one_cycle", 32'(o_ready), 32'd0);
    i_transfer = 1'b1;
    i_write    = wr;
    i_addr     = addr;
    i_wdata    = wdata;

    lat = 0; setup_n = 0; acc_n = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge PCLK);
      lat++;
      if (keep_high) begin
        i_write = 1'($urandom);
        i_addr  = $urandom;
        i_wdata = $urandom;
      end else begin
        i_transfer = 1'b0;
      end
      if (PSEL != '0) begin
        check("psel", 32'(PSEL), 32'(exp_psel));
        check("paddr", 32'(PADDR), 32'(addr[11:0]));
        check("pwrite", 32'(PWRITE), 32'(wr));
        check("pwdata", PWDATA, wdata);
        if (PENABLE) acc_n++;
        else setup_n++;
      end else begin
        check("penable_nosel", 32'(PENABLE), 32'd0);
      end
      if (o_ready) done = 1'b1;
    end

    exp_d = exp_q.pop_front();
    check("complete", 32'(done), 32'd1);
    check("error", 32'(o_error), 32'(exp_err));
    check("rdata", o_rdata, exp_d);
    check("setup_cycles", 32'(setup_n), ok ? 32'd1 : 32'd0);
    check("access_cycles", 32'(acc_n), 32'(exp_acc));
    check("latency", 32'(lat), ok ? 32'(exp_acc + 2) : 32'd1);
    check("done_psel", 32'(PSEL), 32'd0);
    check("done_penable", 32'(PENABLE), 32'd0);
    check("done_busy", 32'(o_busy), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [15:0] hi;
    logic [3:0]  idx;
    logic [11:0] off;
    hi  = ($urandom_range(0, 9) == 0) ? 16'h2000 : 16'h1000;
    idx = 4'($urandom_range(0, 5));
    off = 12'($urandom_range(0, 63));
    return {hi, idx, off};
  endfunction

  task automatic rand_waits();
    for (int k = 0; k < NS; k++)
      wait_n[k] = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vectors    = 0;
    errors     = 0;
    PRESET     = 1'b0;
    i_transfer = 1'b0;
    i_write    = 1'b0;
    i_addr     = '0;
    i_wdata    = '0;
    for (int k = 0; k < 16; k++) begin
      wait_n[k]     = 0;
      fixed_data[k] = 32'hC0DE_0000 | 32'(k);
    end
    fixed_data[2] = 32'h1234_5678;
    model_reset();

    repeat (3) @(negedge PCLK);
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_pwrite", 32'(PWRITE), 32'd0);
    check("rst_paddr", 32'(PADDR), 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    PRESET = 1'b1;

    // RAM write then read back, one wait state.
    wait_n[0] = 1;
    do_req(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b0, 32'h1000_0010, 32'h0, 1'b0);

    // Slave 2 with four wait states while the other slaves toggle PREADY.
    wait_n[2] = 4;
    do_req(1'b0, 32'h1000_2004, 32'h5555_0000, 1'b0);

    // Decode errors: base mismatch and out-of-range index.
    do_req(1'b0, 32'h2000_0000, 32'h0, 1'b0);
    do_req(1'b1, 32'h1000_5000, 32'hFFFF_FFFF, 1'b0);

    // Timeout, then a zero-wait access to the same slave.
    wait_n[1] = 255;
    do_req(1'b0, 32'h1000_1008, 32'h0, 1'b0);
    wait_n[1] = 0;
    do_req(1'b0, 32'h1000_1008, 32'h0, 1'b0);

    // Randomized mix.
    for (int n = 0; n < 40; n++) begin
      rand_waits();
      do_req(1'($urandom), rand_addr(), $urandom, 1'b0);
    end

    // Strobe held high with inputs changing every cycle.
    for (int n = 0; n < 10; n++) begin
      rand_waits();
      do_req(1'($urandom), rand_addr(), $urandom, 1'b1);
    end
    @(negedge PCLK);
    i_transfer = 1'b0;

    // Asynchronous reset in the middle of ACCESS.
    wait_n[0] = 5;
    @(negedge PCLK);
    i_transfer = 1'b1;
    i_write    = 1'b1;
    i_addr     = 32'h1000_0040;
    i_wdata    = 32'hA5A5_5A5A;
    @(negedge PCLK);
    i_transfer = 1'b0;
    @(negedge PCLK);
    check("pre_rst_penable", 32'(PENABLE), 32'd1);
    #2;
    PRESET = 1'b0;
    #1;
    check("async_psel", 32'(PSEL), 32'd0);
    check("async_penable", 32'(PENABLE), 32'd0);
    check("async_busy", 32'(o_busy), 32'd0);
    model_reset();
    for (int n = 0; n < 3; n++) begin
      @(negedge PCLK);
      check("rst_no_ready", 32'(o_ready), 32'd0);
    end
    PRESET = 1'b1;
    do_req(1'b1, 32'h1000_0040, 32'h0BAD_F00D, 1'b0);
    do_req(1'b0, 32'h1000_0040, 32'h0, 1'b0);

    repeat (2) @(negedge PCLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
